// File: rtl/axis_width_upsizer.sv
// axis_width_upsizer
//   Packs IN_BYTES-wide AXI-Stream beats into OUT_BYTES = IN_BYTES*RATIO flits.
//   The beats are collected in an accumulator. Each completed flit is pushed into
//   a show-ahead output FIFO. Input backpressure comes only from FIFO occupancy.
//   The block also reports packet-framing and TID errors, and counts the
//   packets that are popped.
// Ports
//   clk, rst_n      single clock; synchronous active-low reset
//   s_axis_*        narrow input stream; tuser = {sop, byte_count-1}
//   m_axis_*        wide output stream; tuser = {sop, eop, empty bytes}
//   err_status      sticky {tid change, unexpected sop, missing sop}
//   err_clr         clears err_status
//   pkt_count       number of eop flits popped; wraps at 2^32
module axis_width_upsizer #(
   parameter int IN_BYTES   = 16,
   parameter int RATIO      = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int TID_W      = 3,
   parameter int BYTE_SWAP  = 1,
   localparam int CW        = $clog2(IN_BYTES),
   localparam int OUT_BYTES = IN_BYTES*RATIO,
   localparam int EW        = $clog2(OUT_BYTES)
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [IN_BYTES*8-1:0]  s_axis_tdata,
   input  logic [CW:0]            s_axis_tuser,
   input  logic [TID_W-1:0]       s_axis_tid,
   input  logic                   s_axis_tvalid,
   input  logic                   s_axis_tlast,
   output logic                   s_axis_tready,
   output logic [OUT_BYTES*8-1:0] m_axis_tdata,
   output logic [EW+1:0]          m_axis_tuser,
   output logic [TID_W-1:0]       m_axis_tid,
   output logic                   m_axis_tvalid,
   output logic                   m_axis_tlast,
   input  logic                   m_axis_tready,
   output logic [2:0]             err_status,
   input  logic                   err_clr,
   output logic [31:0]            pkt_count
);
   localparam int IW = IN_BYTES*8;
   localparam int OW = OUT_BYTES*8;
   localparam int BW = $clog2(RATIO);
   localparam int PW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [OW-1:0]    data;
      logic             sop;
      logic             eop;
      logic [EW-1:0]    empty;
      logic [TID_W-1:0] tid;
   } flit_t;

   typedef enum logic {S_IDLE, S_IN_PKT} state_t;

   state_t            r_state, w_state_nxt;
   logic [BW-1:0]     r_beat_idx;
   logic [OW-1:0]     r_acc;
   logic              r_sop_acc;
   logic [TID_W-1:0]  r_flit_tid, r_pkt_tid;
   flit_t             r_mem [FIFO_DEPTH];
   logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [PW:0]       r_count;
   logic [2:0]        r_err;
   logic [31:0]       r_pkt_cnt;

   logic              w_accept, w_pop, w_complete, w_in_sop, w_out_vld;
   logic [CW-1:0]     w_cnt;
   logic [IW-1:0]     w_lane;
   logic [OW-1:0]     w_flit_data;
   logic [31:0]       w_used;
   logic [EW-1:0]     w_empty;
   logic [2:0]        w_err_new;
   flit_t             w_push, w_head;

   assign w_in_sop      = s_axis_tuser[CW];
   assign w_cnt         = s_axis_tuser[CW-1:0];
   assign s_axis_tready = rst_n && (r_count < (PW+1)'(FIFO_DEPTH));
   assign w_accept      = s_axis_tvalid && s_axis_tready;
   assign w_complete    = w_accept && ((r_beat_idx == BW'(RATIO-1)) || s_axis_tlast);
   assign w_pop         = m_axis_tvalid && m_axis_tready;

   // Byte-swap the beat and zero the bytes beyond the count on a tlast beat.
   always_comb begin
      w_lane = '0;
      for (int j = 0; j < IN_BYTES; j++) begin
         if (!s_axis_tlast || (CW'(j) <= w_cnt))
            w_lane[j*8 +: 8] = (BYTE_SWAP != 0) ? s_axis_tdata[(IN_BYTES-1-j)*8 +: 8]
                                                : s_axis_tdata[j*8 +: 8];
      end
   end

   // The accumulator is cleared after every flit. Lanes above beat_idx are
   // therefore already zero when a packet ends early.
   always_comb begin
      w_flit_data = r_acc;
      w_flit_data[r_beat_idx*IW +: IW] = w_lane;
   end

   assign w_used  = 32'(r_beat_idx) * 32'(IN_BYTES) + 32'(w_cnt) + 32'd1;
   assign w_empty = s_axis_tlast ? EW'(32'(OUT_BYTES) - w_used) : '0;

   always_comb begin
      w_push.data  = w_flit_data;
      w_push.sop   = r_sop_acc | w_in_sop;
      w_push.eop   = s_axis_tlast;
      w_push.empty = w_empty;
      w_push.tid   = (r_beat_idx == '0) ? s_axis_tid : r_flit_tid;
   end

   assign w_err_new[0] = w_accept && (r_state == S_IDLE) && !w_in_sop;
   assign w_err_new[1] = w_accept && (r_state == S_IN_PKT) && w_in_sop;
   assign w_err_new[2] = w_accept && (r_state == S_IN_PKT) && (s_axis_tid != r_pkt_tid);

   always_comb begin
      w_state_nxt = r_state;
      if (w_accept) w_state_nxt = s_axis_tlast ? S_IDLE : S_IN_PKT;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_beat_idx <= '0;
         r_acc      <= '0;
         r_sop_acc  <= 1'b0;
         r_flit_tid <= '0;
         r_pkt_tid  <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_err      <= '0;
         r_pkt_cnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            if (w_complete) begin
               r_acc      <= '0;
               r_beat_idx <= '0;
               r_sop_acc  <= 1'b0;
            end else begin
               r_acc      <= w_flit_data;
               r_beat_idx <= r_beat_idx + 1'b1;
               r_sop_acc  <= r_sop_acc | w_in_sop;
               if (r_beat_idx == '0) r_flit_tid <= s_axis_tid;
            end
            if (r_state == S_IDLE) r_pkt_tid <= s_axis_tid;
         end
         if (w_complete) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_complete, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // A new error wins over a clear issued in the same cycle.
         r_err <= (err_clr ? 3'b000 : r_err) | w_err_new;
         if (w_pop && w_head.eop) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
   end

   // Storage needs no reset. Stale entries are never visible because the
   // pointers and the count are reset.
   always_ff @(posedge clk) begin
      if (w_complete) r_mem[r_wr_ptr] <= w_push;
   end

   assign w_head        = r_mem[r_rd_ptr];
   assign w_out_vld     = rst_n && (r_count != '0);
   assign m_axis_tvalid = w_out_vld;
   assign m_axis_tdata  = w_out_vld ? w_head.data : '0;
   assign m_axis_tuser  = w_out_vld ? {w_head.sop, w_head.eop, w_head.empty} : '0;
   assign m_axis_tid    = w_out_vld ? w_head.tid : '0;
   assign m_axis_tlast  = w_out_vld && w_head.eop;
   assign err_status    = r_err;
   assign pkt_count     = r_pkt_cnt;
endmodule
